mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one downstream memory port (addr/read/write/wmask/rdata/wdata/resp handshake) between an instruction-fetch requester (read-only) and a data requester (read/write).
- Sits between the core's fetch and LSU ports and the single memory model / cache port.
- Registers each granted request and holds it stable on the downstream port until resp.
- Grants round-robin, and flags protocol violations and response timeouts on a sticky error output.

Parameters:
- TIMEOUT, 1024, number of cycles in a busy state without mem_resp before error is set; must be ≥2.
- CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-low reset
- i_addr  input  32  fetch address, held stable while i_read is high
- i_read  input  1  fetch request, level, held until i_resp
- i_rdata  output  32  fetch read data, valid when i_resp
- i_resp  output  1  fetch completion, one cycle
- d_addr  input  32  data address, held while the request is high
- d_read  input  1  data read request, level
- d_write  input  1  data write request, level
- d_wmask  input  4  byte write enables
- d_wdata  input  32  write data
- d_rdata  output  32  data read data, valid when d_resp
- d_resp  output  1  data completion, one cycle
- mem_addr  output  32  downstream address
- mem_read  output  1  downstream read
- mem_write  output  1  downstream write
- mem_wmask  output  4  downstream byte enables, 0 on reads
- mem_wdata  output  32  downstream write data
- mem_rdata  input  32  downstream read data
- mem_resp  input  1  downstream completion
- busy  output  1  high in BUSY_I or BUSY_D
- error  output  1  sticky violation/timeout flag

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst). When rst==0 at a rising edge, the block is in reset.
- Reset values:
  - state=IDLE, rr_last=D (so I wins the first tie).
  - mem_addr=0, mem_read=0, mem_write=0, mem_wmask=0, mem_wdata=0.
  - busy=0, error=0, timeout counter=0.
  - Reset mid-transaction abandons the transaction immediately; no resp is returned upstream.
- States IDLE, BUSY_I, BUSY_D. mem_* outputs are registered.
- IDLE transitions:
  - Only i_read high → BUSY_I; latch i_addr, mem_read=1.
  - Only d_read or d_write high → BUSY_D; latch d_addr, d_wmask, d_wdata, and the read or write.
  - Both requesting → grant the requester that is not rr_last. rr_last updates to the grantee.
  - Request sampled in cycle N → mem_read or mem_write high in cycle N+1.
- BUSY_x:
  - mem_* held constant.
  - When mem_resp==1 in cycle M: x_resp=1 combinationally in cycle M; x_rdata=mem_rdata (passthrough in all cycles); the other port's resp stays 0.
  - Next state IDLE, so mem_read/mem_write are 0 in cycle M+1.
  - A new grant is decided in M+1, and the next transaction reaches mem_* in M+2. Minimum one dead cycle between transactions.
- i_resp/d_resp are never high outside their own BUSY state.
- mem_wmask=0 for all reads. Fetch requests never write.
- Timeout counter:
  - Clears on entering BUSY and increments each BUSY cycle without mem_resp.
  - Reaching TIMEOUT sets error; the transaction continues waiting and is not aborted.
  - Counter saturates and does not wrap.
- error set (sticky until reset) on any of:
  - d_read && d_write in the same cycle;
  - mem_resp==1 while IDLE (spurious);
  - timeout.
- On d_read && d_write, the arbiter treats the request as a write.
- Requests arriving while BUSY simply wait; changes to the waiting requester's inputs before its grant are legal.

Test Plan:
- Single fetch: i_read=1, i_addr=0x0000_1000 at cycle 0; memory replies mem_resp at cycle 3 with mem_rdata=0xDEADBEEF → mem_read=1, mem_addr=0x1000 in cycles 1–3; i_resp=1, i_rdata=0xDEADBEEF at cycle 3; mem_read=0 at cycle 4; d_resp never high.
- Simultaneous requests after reset: i_read (0x100) and d_write (0x200, wmask=4'b0011, wdata=0x1234_5678) both at cycle 0 → fetch served first; the write appears on mem_* with mem_wmask=0011 two cycles after the fetch resp.
  - Repeat the same simultaneous request → data is served first (round-robin alternation).
- Back-to-back data reads with a 1-cycle memory: d_read held across two transactions → one idle cycle between mem_read pulses; each d_resp pulses exactly one cycle.
- Timeout with TIMEOUT=8: grant a read and withhold mem_resp → error=1 after 8 busy cycles; a later mem_resp still produces d_resp, and error stays 1.
- Protocol errors:
  - d_read=d_write=1 → error=1 and a write is issued.
  - After reset, mem_resp pulsed while IDLE → error=1.
- Reset mid-transaction: rst=0 while in BUSY_D → next cycle mem_write=0, busy=0, error=0, no d_resp. After rst returns to 1, a fresh i_read is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single downstream memory port.
// Fetch (read-only) and data (read/write) requests are granted round-robin on
// ties, registered onto mem_*, and held until mem_resp. Protocol violations and
// response timeouts raise a sticky error flag.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 11
) (
  input  logic        clk,
  input  logic        rst,
  // fetch requester
  input  logic [31:0] i_addr,
  input  logic        i_read,
  output logic [31:0] i_rdata,
  output logic        i_resp,
  // data requester
  input  logic [31:0] d_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [3:0]  d_wmask,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_resp,
  // downstream memory port
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  // status
  output logic        busy,
  output logic        error
);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

  state_e      state_q, state_d;
  logic        rr_last_d_q, rr_last_d_d;  // 1: data won the most recent tie
  logic [31:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  wmask_q, wmask_d;
  logic [31:0] wdata_q, wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        error_q, error_d;

  logic req_i, req_d, grant_i, grant_d;

  assign req_i = i_read;
  assign req_d = d_read | d_write;

  // Next-state: arbitration in idle, hold-and-count while busy, error capture.
  always_comb begin
    state_d     = state_q;
    rr_last_d_d = rr_last_d_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    wmask_d     = wmask_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    error_d     = error_q;
    grant_i     = 1'b0;
    grant_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_i && req_d) begin
          // Tie: the requester that did not win the last tie goes first.
          grant_i     = rr_last_d_q;
          grant_d     = !rr_last_d_q;
          rr_last_d_d = !rr_last_d_q;
        end else begin
          grant_i = req_i;
          grant_d = req_d;
        end

        if (grant_i) begin
          state_d = StBusyI;
          addr_d  = i_addr;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          wmask_d = 4'b0000;
          cnt_d   = '0;
        end else if (grant_d) begin
          // A simultaneous read+write is served as a write.
          state_d = StBusyD;
          addr_d  = d_addr;
          rd_d    = !d_write;
          wr_d    = d_write;
          wmask_d = d_write ? d_wmask : 4'b0000;
          wdata_d = d_wdata;
          cnt_d   = '0;
        end

        // Response with nothing outstanding.
        if (mem_resp) error_d = 1'b1;
      end

      StBusyI, StBusyD: begin
        if (mem_resp) begin
          state_d = StIdle;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          wmask_d = 4'b0000;
        end else if (cnt_q != TimeoutCnt) begin
          // Saturating wait counter; the transaction keeps waiting after timeout.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TimeoutCnt - 1'b1) error_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase

    if (d_read && d_write) error_d = 1'b1;
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      rr_last_d_q <= 1'b1;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      wmask_q     <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_d_q <= rr_last_d_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      wmask_q     <= wmask_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      error_q     <= error_d;
    end
  end

  // Outputs: registered memory side, combinational completions.
  always_comb begin
    mem_addr  = addr_q;
    mem_read  = rd_q;
    mem_write = wr_q;
    mem_wmask = wmask_q;
    mem_wdata = wdata_q;
    i_rdata   = mem_rdata;
    d_rdata   = mem_rdata;
    i_resp    = (state_q == StBusyI) && mem_resp;
    d_resp    = (state_q == StBusyD) && mem_resp;
    busy      = (state_q != StIdle);
    error     = error_q;
  end

endmodule
